// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - speed/direction ramp sequencer for one PWM channel and H-bridge
module motor_ramp_ctrl #(
    parameter int RAMP_DIV = 1_000_000,
    parameter int DEADTIME = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_speed,
    input  logic       cmd_dir,
    input  logic       estop,
    output logic [3:0] pwm_speed,
    output logic       pwm_enable,
    output logic       dir,
    output logic       at_speed,
    output logic       busy
);

    // Counter widths are floored at one bit so the minimum legal parameters still build.
    localparam int PW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME - 1);

    typedef enum logic [1:0] {IDLE, RUN, DEAD, HALT} state_t;

    state_t        state, state_n;
    logic [3:0]    target_speed, target_speed_n;
    logic          target_dir, target_dir_n;
    logic [3:0]    cur_speed, cur_speed_n;
    logic          cur_dir, cur_dir_n;
    logic [PW-1:0] presc, presc_n;
    logic [DW-1:0] dead_cnt, dead_cnt_n;
    logic          step_tick;
    logic          dir_match;

    assign step_tick = (presc == PRESC_LAST);
    assign dir_match = (target_dir == cur_dir);

    always_comb begin
        state_n        = state;
        target_speed_n = target_speed;
        target_dir_n   = target_dir;
        cur_speed_n    = cur_speed;
        cur_dir_n      = cur_dir;
        presc_n        = presc;
        dead_cnt_n     = dead_cnt;

        case (state)
            IDLE: begin
                presc_n = step_tick ? '0 : presc + 1'b1;
                if (target_speed != 4'd0) begin
                    state_n = dir_match ? RUN : DEAD;
                end
            end
            RUN: begin
                presc_n = step_tick ? '0 : presc + 1'b1;
                if (dir_match && target_speed == 4'd0 && cur_speed == 4'd0) begin
                    state_n = IDLE;
                end else if (step_tick) begin
                    if (dir_match) begin
                        if (cur_speed < target_speed) begin
                            cur_speed_n = cur_speed + 4'd1;
                        end else if (cur_speed > target_speed) begin
                            cur_speed_n = cur_speed - 4'd1;
                        end
                    end else if (cur_speed <= 4'd1) begin
                        // Ramp-down finished: the step that reaches zero also starts the dead time.
                        cur_speed_n = 4'd0;
                        state_n     = DEAD;
                    end else begin
                        cur_speed_n = cur_speed - 4'd1;
                    end
                end
            end
            DEAD: begin
                cur_speed_n = 4'd0;
                if (dead_cnt == DEAD_LAST) begin
                    cur_dir_n  = target_dir;
                    presc_n    = '0;
                    dead_cnt_n = '0;
                    state_n    = (target_speed != 4'd0) ? RUN : IDLE;
                end else begin
                    dead_cnt_n = dead_cnt + 1'b1;
                end
            end
            HALT: begin
                cur_speed_n = 4'd0;
                presc_n     = '0;
                dead_cnt_n  = '0;
                state_n     = DEAD;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A new command restarts the ramp phase so its first step is a full period away.
        if (cmd_valid) begin
            target_speed_n = cmd_speed;
            target_dir_n   = cmd_dir;
            presc_n        = '0;
        end

        // Emergency stop overrides everything, including a command on the same edge.
        if (estop) begin
            state_n        = HALT;
            cur_speed_n    = 4'd0;
            presc_n        = '0;
            dead_cnt_n     = '0;
            target_speed_n = target_speed;
            target_dir_n   = target_dir;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            target_speed <= 4'd0;
            target_dir   <= 1'b0;
            cur_speed    <= 4'd0;
            cur_dir      <= 1'b0;
            presc        <= '0;
            dead_cnt     <= '0;
        end else begin
            state        <= state_n;
            target_speed <= target_speed_n;
            target_dir   <= target_dir_n;
            cur_speed    <= cur_speed_n;
            cur_dir      <= cur_dir_n;
            presc        <= presc_n;
            dead_cnt     <= dead_cnt_n;
        end
    end

    assign pwm_speed  = cur_speed;
    assign pwm_enable = (cur_speed != 4'd0);
    assign dir        = cur_dir;
    assign at_speed   = (cur_speed == target_speed) && dir_match && (state == IDLE || state == RUN);
    assign busy       = ~at_speed;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb/tb_motor_ramp_ctrl.sv - randomized and directed checks of motor_ramp_ctrl against a timeline model
module tb_motor_ramp_ctrl;

    localparam int R = 4;
    localparam int D = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DEAD = 2;
    localparam int M_HALT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_speed = 4'd0;
    logic       cmd_dir = 1'b0;
    logic       estop = 1'b0;
    logic [3:0] pwm_speed;
    logic       pwm_enable;
    logic       dir;
    logic       at_speed;
    logic       busy;
    logic [7:0] outs;

    int vectors = 0;
    int miscompares = 0;

    // Model: mode, speeds, directions, the edge at which the ramp phase last restarted
    // (steps fall every R edges after it) and the edge at which the dead time ends.
    int edge_no = 0;
    int m_mode = M_IDLE;
    int m_spd = 0, m_cdir = 0, m_tsp = 0, m_tdir = 0;
    int m_anchor = 0, m_dead_end = 0;

    motor_ramp_ctrl #(.RAMP_DIV(R), .DEADTIME(D)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_speed(cmd_speed),
        .cmd_dir(cmd_dir), .estop(estop), .pwm_speed(pwm_speed), .pwm_enable(pwm_enable),
        .dir(dir), .at_speed(at_speed), .busy(busy)
    );

    assign outs = {pwm_speed, pwm_enable, dir, at_speed, busy};

    always #5 clock = ~clock;

    function automatic logic [7:0] exp_vec();
        logic at;
        at = (m_spd == m_tsp) && (m_cdir == m_tdir) && (m_mode == M_IDLE || m_mode == M_RUN);
        return {4'(m_spd), 1'(m_spd != 0), 1'(m_cdir), at, ~at};
    endfunction

    task automatic model_edge();
        int  e;
        bit  tick;
        e = edge_no;
        if (reset) begin
            m_mode = M_IDLE; m_spd = 0; m_cdir = 0; m_tsp = 0; m_tdir = 0;
            m_anchor = e; m_dead_end = 0;
        end else if (estop) begin
            m_mode = M_HALT; m_spd = 0;
        end else begin
            tick = (m_mode == M_IDLE || m_mode == M_RUN) && ((e - m_anchor) % R == 0);
            case (m_mode)
                M_IDLE: if (m_tsp != 0) begin
                    if (m_tdir != m_cdir) begin m_mode = M_DEAD; m_dead_end = e + D; end
                    else m_mode = M_RUN;
                end
                M_RUN: begin
                    if (m_tdir == m_cdir && m_tsp == 0 && m_spd == 0) m_mode = M_IDLE;
                    else if (tick) begin
                        if (m_tdir == m_cdir) begin
                            if (m_tsp > m_spd) m_spd = m_spd + 1;
                            else if (m_tsp < m_spd) m_spd = m_spd - 1;
                        end else begin
                            m_spd = (m_spd > 0) ? m_spd - 1 : 0;
                            if (m_spd == 0) begin m_mode = M_DEAD; m_dead_end = e + D; end
                        end
                    end
                end
                M_DEAD: if (e == m_dead_end) begin
                    m_cdir = m_tdir; m_anchor = e;
                    m_mode = (m_tsp != 0) ? M_RUN : M_IDLE;
                end
                default: begin m_mode = M_DEAD; m_dead_end = e + D; end
            endcase
            if (cmd_valid) begin
                m_tsp = int'(cmd_speed); m_tdir = int'(cmd_dir); m_anchor = e;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        edge_no++;
        model_edge();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; estop = 1'b0; cmd_valid = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic issue_cmd(input logic [3:0] spd, input logic d);
        cmd_speed = spd; cmd_dir = d; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (outs !== 8'b0000_0_0_1_0) begin
            miscompares++;
            $display("FAIL reset_values: got %b expected %b", outs, 8'b0000_0_0_1_0);
        end
        vectors++;
        if (outs !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_model: got %b expected %b", outs, exp_vec());
        end
    endtask

    task automatic test_ramp_up();
        do_reset();
        issue_cmd(4'd5, 1'b0);
        for (int k = 1; k <= 6 * R; k++) begin
            step();
            vectors++;
            if (outs !== exp_vec()) begin
                miscompares++;
                $display("FAIL ramp_up_model edge N+%0d: got %b expected %b", k, outs, exp_vec());
            end
            if (k % R == 0 && k <= 5 * R) begin
                vectors++;
                if (pwm_speed !== 4'(k / R) || pwm_enable !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ramp_up_step edge N+%0d: got speed %0d en %b expected %0d en 1", k, pwm_speed, pwm_enable, k / R);
                end
            end
            if (k == 5 * R - 1 || k == 5 * R) begin
                vectors++;
                if (at_speed !== 1'(k == 5 * R)) begin
                    miscompares++;
                    $display("FAIL ramp_up_at_speed edge N+%0d: got %b expected %b", k, at_speed, k == 5 * R);
                end
            end
        end
    endtask

    task automatic test_reversal();
        logic [3:0] exp_s [int];
        exp_s[4] = 4'd2; exp_s[8] = 4'd1; exp_s[12] = 4'd0; exp_s[24] = 4'd1; exp_s[28] = 4'd2;
        do_reset();
        issue_cmd(4'd3, 1'b0);
        repeat (4 * R) step();
        issue_cmd(4'd2, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            step();
            vectors++;
            if (outs !== exp_vec()) begin
                miscompares++;
                $display("FAIL reversal_model edge N+%0d: got %b expected %b", k, outs, exp_vec());
            end
            if (exp_s.exists(k)) begin
                vectors++;
                if (pwm_speed !== exp_s[k] || pwm_enable !== (exp_s[k] != 4'd0)) begin
                    miscompares++;
                    $display("FAIL reversal_speed edge N+%0d: got %0d en %b expected %0d", k, pwm_speed, pwm_enable, exp_s[k]);
                end
            end
            if (k == 19 || k == 20) begin
                vectors++;
                if (dir !== 1'(k == 20)) begin
                    miscompares++;
                    $display("FAIL reversal_dir edge N+%0d: got %b expected %b", k, dir, k == 20);
                end
            end
        end
    endtask

    task automatic test_idle_reversal();
        do_reset();
        issue_cmd(4'd1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step();
            vectors++;
            if (outs !== exp_vec()) begin
                miscompares++;
                $display("FAIL idle_rev_model edge %0d: got %b expected %b", k, outs, exp_vec());
            end
            if (k == 8 || k == 9) begin
                vectors++;
                if (dir !== 1'(k == 9)) begin
                    miscompares++;
                    $display("FAIL idle_rev_dir edge %0d: got %b expected %b", k, dir, k == 9);
                end
            end
            if (k == 12 || k == 13) begin
                vectors++;
                if (pwm_speed !== 4'(k == 13)) begin
                    miscompares++;
                    $display("FAIL idle_rev_speed edge %0d: got %0d expected %0d", k, pwm_speed, k == 13);
                end
            end
        end
    endtask

    task automatic test_estop();
        do_reset();
        issue_cmd(4'd7, 1'b0);
        repeat (8 * R) step();
        estop = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            vectors++;
            if (pwm_speed !== 4'd0 || busy !== 1'b1 || outs !== exp_vec()) begin
                miscompares++;
                $display("FAIL estop_hold cycle %0d: got %b expected %b", k, outs, exp_vec());
            end
        end
        estop = 1'b0;
        for (int k = 1; k <= 1 + D + 7 * R + 2; k++) begin
            step();
            vectors++;
            if (outs !== exp_vec() || dir !== 1'b0) begin
                miscompares++;
                $display("FAIL estop_recover edge R+%0d: got %b expected %b", k, outs, exp_vec());
            end
            if (k == D || k == 1 + D + R || k == 1 + D + 7 * R) begin
                vectors++;
                if (pwm_speed !== ((k == D) ? 4'd0 : 4'((k - 1 - D) / R))) begin
                    miscompares++;
                    $display("FAIL estop_ramp edge R+%0d: got %0d expected %0d", k, pwm_speed, (k == D) ? 0 : (k - 1 - D) / R);
                end
            end
        end
    endtask

    task automatic test_mid_ramp();
        do_reset();
        issue_cmd(4'd10, 1'b0);
        repeat (6 * R + 1) step();
        vectors++;
        if (pwm_speed !== 4'd6) begin
            miscompares++;
            $display("FAIL mid_ramp_pre: got %0d expected 6", pwm_speed);
        end
        issue_cmd(4'd4, 1'b0);
        for (int k = 1; k <= 4 * R; k++) begin
            step();
            vectors++;
            if (outs !== exp_vec() || at_speed !== 1'(k >= 2 * R)) begin
                miscompares++;
                $display("FAIL mid_ramp edge N+%0d: got %b expected %b", k, outs, exp_vec());
            end
            if (k == R || k >= 2 * R) begin
                vectors++;
                if (pwm_speed !== ((k == R) ? 4'd5 : 4'd4)) begin
                    miscompares++;
                    $display("FAIL mid_ramp_speed edge N+%0d: got %0d expected %0d", k, pwm_speed, (k == R) ? 5 : 4);
                end
            end
        end
    endtask

    task automatic test_reset_in_dead();
        do_reset();
        issue_cmd(4'd1, 1'b1);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (outs !== 8'b0000_0_0_1_0) begin
            miscompares++;
            $display("FAIL reset_in_dead: got %b expected %b", outs, 8'b0000_0_0_1_0);
        end
        for (int k = 1; k <= 2 * D; k++) begin
            step();
            vectors++;
            if (outs !== 8'b0000_0_0_1_0 || outs !== exp_vec()) begin
                miscompares++;
                $display("FAIL post_reset_quiet edge %0d: got %b expected %b", k, outs, 8'b0000_0_0_1_0);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if (estop) estop = ($urandom_range(0, 3) != 0);
            else       estop = ($urandom_range(0, 149) == 0);
            cmd_valid = !estop && ($urandom_range(0, 13) == 0);
            cmd_speed = 4'($urandom_range(0, 15));
            cmd_dir   = 1'($urandom_range(0, 1));
            step();
            vectors++;
            if (outs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b expected %b", i, outs, exp_vec());
            end
        end
        reset = 1'b0; estop = 1'b0; cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reversal();
        test_idle_reversal();
        test_estop();
        test_mid_ramp();
        test_reset_in_dead();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
# motor_ramp_ctrl

Speed/direction sequencer placed between the rover command logic (switch inputs or higher-level controller) and one PWM generator plus H-bridge direction pin. Commanded 4-bit speed and direction are latched, and the PWM `speed` value ramps one step at a time at a fixed rate. Direction reversals always ramp to zero and hold a dead time with PWM disabled before the direction pin flips. An emergency-stop input cuts drive immediately.

## Interface
- `RAMP_DIV`, 1_000_000: clock cycles per speed step, ≥2 (10 ms at 100 MHz).
- `DEADTIME`, 5_000_000: cycles with drive off before a direction flip, ≥1 (50 ms).

- `clock`  in  1  system clock, 100 MHz, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  single-cycle strobe; latches `cmd_speed`/`cmd_dir`.
- `cmd_speed`  in  4  target speed 0–15.
- `cmd_dir`  in  1  target direction, 0 = forward.
- `estop`  in  1  level; immediate stop while high.
- `pwm_speed`  out  4  to PWM `speed`; equals current speed register.
- `pwm_enable`  out  1  to PWM `enable`; `pwm_speed != 0`.
- `dir`  out  1  to H-bridge; current direction register.
- `at_speed`  out  1  `pwm_speed == target_speed && dir == target_dir` and state is IDLE or RUN.
- `busy`  out  1  `!at_speed`.

## Operation
- Registers: `target_speed`, `target_dir`, `cur_speed` (drives `pwm_speed`), `cur_dir` (drives `dir`), `state`, prescaler (`$clog2(RAMP_DIV)` bits), dead counter (`$clog2(DEADTIME)` bits).
- `cmd_valid` latches target in any state, including HALT and DEAD, and clears the prescaler to 0.
- Prescaler counts in IDLE and RUN and wraps at `RAMP_DIV-1`. A step tick is the cycle where prescaler == `RAMP_DIV-1`.
- States:
  - IDLE: `cur_speed` is 0. If `target_speed != 0`: go to DEAD if `target_dir != cur_dir`, else go to RUN. Otherwise stay in IDLE.
  - RUN: on a step tick:
    - If dirs match, `cur_speed` moves ±1 toward `target_speed`. At speed, it holds.
    - If dirs differ, `cur_speed` decrements. The step that yields 0 enters DEAD on the same edge.
    - If dirs match and both speeds are 0, enter IDLE. This is checked every cycle, not only on ticks.
  - DEAD: `cur_speed` held at 0. The dead counter counts 0..`DEADTIME-1`. At the last count: `cur_dir <= target_dir`, prescaler cleared, dead counter cleared. Next state is RUN if `target_speed != 0`, else IDLE.
  - HALT: `cur_speed` 0; counters frozen at 0. Leave on the first edge with `estop` low, entering DEAD with the full dead time.
- Priority at an edge: `reset` > `estop` > `cmd_valid` latch > state transition. `estop` high in any state gives `cur_speed` 0 and HALT at that edge. `cur_dir` is unchanged.
- Speed is never written outside 0–15. No overflow or underflow is possible since steps are ±1 toward a 4-bit target.

## Timing
- Reset values: `pwm_speed` 0, `pwm_enable` 0, `dir` 0, `at_speed` 1, `busy` 0. Target 0/0, state IDLE, counters 0.
- All outputs are registered or decoded from registers only. There is no input-to-output combinational path.
- Command accepted at edge N with no reversal: first speed step at edge N+`RAMP_DIV`, then every `RAMP_DIV` cycles. This holds from both IDLE and RUN.
- Reversal from speed S: zero reached at edge N+S·`RAMP_DIV`. `dir` flips at edge N+S·`RAMP_DIV`+`DEADTIME`. The first step of the new direction follows `RAMP_DIV` cycles later.
- Reversal from IDLE: DEAD entered at edge N+1, and `dir` flips at edge N+1+`DEADTIME`.
- Mid-ramp command: the new target takes effect from the next tick. The ramp phase restarts at the command edge.
- Target set back to `cur_dir` during the ramp-down: direction mismatch clears, so the ramp reverses toward the new target with no DEAD.
- Reset mid-operation returns every register to its reset value at that edge.

## Test plan
Bench uses `RAMP_DIV`=4, `DEADTIME`=8.
- Reset, then `cmd_valid` at edge 0 with speed 5, dir 0 -> `pwm_speed` 1 after edge 4, 2@8 … 5@20. `at_speed` rises after edge 20; `pwm_enable` high from edge 4.
- From 3/fwd, command 2/rev at edge N -> speeds 2,1,0 after N+4,8,12. `pwm_enable` low from N+12. `dir`=1 after N+20. Speed 1@N+24, 2@N+28.
- From IDLE dir 0, command 1/rev at edge 0 -> DEAD at edge 1, `dir`=1 after edge 9, `pwm_speed` 1 after edge 13.
- At 7/fwd, `estop` high for 3 cycles -> `pwm_speed` 0 on the first edge. DEAD for 8 cycles after release, then ramp from 0 back to 7 with `dir` unchanged.
- Ramping 0->10, command 4/fwd when speed is 6 -> ramp reverses downward and settles at 4. `at_speed` asserts only at 4.
- Assert `reset` during DEAD -> all outputs at reset values next edge. No `dir` flip occurs afterwards without a new command.
